// File: rtl/matmul_8x8_output_collector.sv
// Write-back collector for the 8x8 systolic matmul: buffers the two bottom-row tile streams
// and round-robins them onto one C-memory write port. Optional macro: COLLECTOR_OVERFLOW_CHECK_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | after reset; available strobes ignored
// S_COLLECT | lanes push into FIFOs, arbiter drains them to memory
// S_DONE    | all 2*WORDS_PER_LANE words written; inputs ignored
module matmul_8x8_output_collector #(
   parameter int DWIDTH          = 8,
   parameter int AWIDTH          = 11,
   parameter int BB_MAT_MUL_SIZE = 4,
   parameter int FIFO_DEPTH      = 4,
   parameter int WORDS_PER_LANE  = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start_collect,
   input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_data_1_0,
   input  logic [AWIDTH-1:0]                 c_addr_1_0,
   input  logic                              c_data_1_0_available,
   input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_data_1_1,
   input  logic [AWIDTH-1:0]                 c_addr_1_1,
   input  logic                              c_data_1_1_available,
   output logic                              mem_wr_en,
   output logic [AWIDTH-1:0]                 mem_wr_addr,
   output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] mem_wr_data,
   input  logic                              mem_wr_ready,
   output logic                              collect_done,
   output logic                              overflow_err
);
   localparam int WW    = BB_MAT_MUL_SIZE * DWIDTH;
   localparam int EW    = AWIDTH + WW;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int TOTAL = 2 * WORDS_PER_LANE;
   localparam int CW    = $clog2(TOTAL + 1);
   localparam logic [PW:0]   PTR_ONE = 1;
   localparam logic [CW-1:0] CNT_ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

   state_t            r_state, w_next;
   logic [EW-1:0]     r_fifo [2][FIFO_DEPTH];
   logic [PW:0]       r_wptr [2];
   logic [PW:0]       r_rptr [2];
   logic [CW-1:0]     r_count;
   logic              r_rr_ptr;
   logic              r_stall;
   logic              r_stall_lane;

   logic [EW-1:0]     w_in [2];
   logic [1:0]        w_avail, w_empty, w_full, w_push, w_pop;
   logic              w_grant, w_wr_en, w_accept, w_live;
   logic [EW-1:0]     w_head;

   assign w_in[0]  = {c_addr_1_0, c_data_1_0};
   assign w_in[1]  = {c_addr_1_1, c_data_1_1};
   assign w_avail  = {c_data_1_1_available, c_data_1_0_available};
   assign w_live   = (r_state == S_COLLECT) && !start_collect;

   always_comb begin
      w_empty = '0;
      w_full  = '0;
      for (int l = 0; l < 2; l++) begin
         w_empty[l] = (r_wptr[l] == r_rptr[l]);
         w_full[l]  = (r_wptr[l][PW] != r_rptr[l][PW]) &&
                      (r_wptr[l][PW-1:0] == r_rptr[l][PW-1:0]);
      end
   end

   // A stalled request keeps its lane even if the other lane becomes non-empty meanwhile.
   always_comb begin
      w_grant = r_rr_ptr;
      if (r_stall)
         w_grant = r_stall_lane;
      else if (w_empty[r_rr_ptr])
         w_grant = ~r_rr_ptr;
   end

   assign w_head   = r_fifo[w_grant][r_rptr[w_grant][PW-1:0]];
   assign w_wr_en  = (r_state == S_COLLECT) && !w_empty[w_grant];
   assign w_accept = w_wr_en && mem_wr_ready;

   always_comb begin
      w_pop  = '0;
      w_push = '0;
      for (int l = 0; l < 2; l++) begin
         w_pop[l]  = w_accept && !start_collect && (w_grant == 1'(l));
         w_push[l] = w_live && w_avail[l] && (!w_full[l] || w_pop[l]);
      end
   end

   assign mem_wr_en    = w_wr_en;
   assign mem_wr_addr  = w_wr_en ? w_head[EW-1:WW] : '0;
   assign mem_wr_data  = w_wr_en ? w_head[WW-1:0]  : '0;
   assign collect_done = (r_state == S_DONE);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_COLLECT: if (w_accept && r_count == CW'(TOTAL - 1)) w_next = S_DONE;
         default:   w_next = r_state;
      endcase
      if (start_collect)
         w_next = S_COLLECT;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_rr_ptr     <= 1'b0;
         r_stall      <= 1'b0;
         r_stall_lane <= 1'b0;
         for (int l = 0; l < 2; l++) begin
            r_wptr[l] <= '0;
            r_rptr[l] <= '0;
         end
      end else begin
         r_state <= w_next;
         if (start_collect) begin
            r_count  <= '0;
            r_rr_ptr <= 1'b0;
            r_stall  <= 1'b0;
            for (int l = 0; l < 2; l++) begin
               r_wptr[l] <= '0;
               r_rptr[l] <= '0;
            end
         end else begin
            for (int l = 0; l < 2; l++) begin
               if (w_push[l]) r_wptr[l] <= r_wptr[l] + PTR_ONE;
               if (w_pop[l])  r_rptr[l] <= r_rptr[l] + PTR_ONE;
            end
            if (w_accept && r_count != CW'(TOTAL)) begin
               r_count  <= r_count + CNT_ONE;
               r_rr_ptr <= ~w_grant;
            end
            r_stall      <= w_wr_en && !mem_wr_ready;
            r_stall_lane <= w_grant;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < 2; l++)
         if (w_push[l]) r_fifo[l][r_wptr[l][PW-1:0]] <= w_in[l];
   end

`ifdef COLLECTOR_OVERFLOW_CHECK_EN
   logic       r_overflow;
   logic [1:0] w_drop;

   always_comb begin
      w_drop = '0;
      for (int l = 0; l < 2; l++)
         w_drop[l] = w_live && w_avail[l] && w_full[l] && !w_pop[l];
   end

   always_ff @(posedge clk) begin
      if (!reset)
         r_overflow <= 1'b0;
      else if (start_collect)
         r_overflow <= 1'b0;
      else if (|w_drop)
         r_overflow <= 1'b1;
   end

   assign overflow_err = r_overflow;
`else
   assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_8x8_output_collector.sv
// Scoreboard bench for matmul_8x8_output_collector: stimulus queues expected writes per lane,
// a negedge monitor pops and compares every accepted write and checks stall stability.
module tb_matmul_8x8_output_collector;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_collect = 1'b0;
   logic [31:0] c_data_1_0 = '0;
   logic [10:0] c_addr_1_0 = '0;
   logic        c_data_1_0_available = 1'b0;
   logic [31:0] c_data_1_1 = '0;
   logic [10:0] c_addr_1_1 = '0;
   logic        c_data_1_1_available = 1'b0;
   logic        mem_wr_en;
   logic [10:0] mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic        mem_wr_ready = 1'b0;
   logic        collect_done;
   logic        overflow_err;

   int n_vec = 0;
   int n_err = 0;
   logic [42:0] exp_q0[$];
   logic [42:0] exp_q1[$];
   bit          lane_log[$];
   bit          tog = 1'b0;
   bit          prev_stall = 1'b0;
   logic [10:0] prev_addr;
   logic [31:0] prev_data;
   logic        exp_ovf;

   always #5 clk = ~clk;

   matmul_8x8_output_collector dut (
      .clk(clk), .reset(reset), .start_collect(start_collect),
      .c_data_1_0(c_data_1_0), .c_addr_1_0(c_addr_1_0),
      .c_data_1_0_available(c_data_1_0_available),
      .c_data_1_1(c_data_1_1), .c_addr_1_1(c_addr_1_1),
      .c_data_1_1_available(c_data_1_1_available),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_wr_ready(mem_wr_ready), .collect_done(collect_done), .overflow_err(overflow_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: lane is identified by address bit 4 (lane 0 uses 0-15, lane 1 uses 16-31).
   always @(negedge clk) begin
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_hold_en", 64'(mem_wr_en), 64'd1);
            check("stall_hold_addr", 64'(mem_wr_addr), 64'(prev_addr));
            check("stall_hold_data", 64'(mem_wr_data), 64'(prev_data));
         end
         if (mem_wr_en && mem_wr_ready) begin
            if (mem_wr_addr[4] == 1'b0) begin
               if (exp_q0.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_write lane0: got %0h/%0h, expected none", mem_wr_addr, mem_wr_data);
               end else
                  check("wr_word_lane0", 64'({mem_wr_addr, mem_wr_data}), 64'(exp_q0.pop_front()));
            end else begin
               if (exp_q1.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_write lane1: got %0h/%0h, expected none", mem_wr_addr, mem_wr_data);
               end else
                  check("wr_word_lane1", 64'({mem_wr_addr, mem_wr_data}), 64'(exp_q1.pop_front()));
            end
            lane_log.push_back(mem_wr_addr[4]);
         end
         prev_stall = mem_wr_en && !mem_wr_ready && !start_collect;
         prev_addr  = mem_wr_addr;
         prev_data  = mem_wr_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (tog) mem_wr_ready = ~mem_wr_ready;
   endtask

   task automatic pulse_start();
      start_collect = 1'b1;
      step();
      start_collect = 1'b0;
   endtask

   task automatic drive0(input int a, input logic [31:0] d, input bit expect_write);
      c_data_1_0_available = 1'b1;
      c_addr_1_0 = 11'(a);
      c_data_1_0 = d;
      if (expect_write) exp_q0.push_back({11'(a), d});
   endtask

   task automatic drive1(input int a, input logic [31:0] d, input bit expect_write);
      c_data_1_1_available = 1'b1;
      c_addr_1_1 = 11'(a);
      c_data_1_1 = d;
      if (expect_write) exp_q1.push_back({11'(a), d});
   endtask

   task automatic idle_lanes();
      c_data_1_0_available = 1'b0;
      c_data_1_1_available = 1'b0;
   endtask

   // Returns at the negedge of the cycle whose edge carries the last expected write.
   task automatic wait_drain(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         #1;
         if (exp_q0.size() == 0 && exp_q1.size() == 0) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      check({name, "_drain"}, 64'(ok), 64'd1);
   endtask

   initial begin
`ifdef COLLECTOR_OVERFLOW_CHECK_EN
      exp_ovf = 1'b1;
`else
      exp_ovf = 1'b0;
`endif
      step();
      step();
      check("rst_wr_en", 64'(mem_wr_en), 64'd0);
      check("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
      check("rst_wr_data", 64'(mem_wr_data), 64'd0);
      check("rst_done", 64'(collect_done), 64'd0);
      check("rst_overflow", 64'(overflow_err), 64'd0);
      reset = 1'b1;
      step();

      // Lane 0 alone: each word presented one cycle after its push
      mem_wr_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         drive0(i, 32'h11111111 * 32'(i + 1), 1'b1);
         step();
         @(negedge clk);
         #1;
         check("t1_latency_en", 64'(mem_wr_en), 64'd1);
         check("t1_latency_addr", 64'(mem_wr_addr), 64'(i));
      end
      idle_lanes();
      wait_drain("t1");
      step();
      step();
      check("t1_done_low", 64'(collect_done), 64'd0);

      // Both lanes: alternating writes, done one cycle after the 8th
      pulse_start();
      lane_log.delete();
      for (int i = 0; i < 4; i++) begin
         drive0(i, 32'hA0000000 + 32'(i), 1'b1);
         drive1(16 + i, 32'hB0000000 + 32'(i), 1'b1);
         step();
      end
      idle_lanes();
      wait_drain("t2");
      check("t2_done_before_last", 64'(collect_done), 64'd0);
      step();
      check("t2_done", 64'(collect_done), 64'd1);
      begin
         logic [7:0] pat = '0;
         for (int i = 0; i < lane_log.size() && i < 8; i++) pat[i] = lane_log[i];
         check("t2_write_count", 64'(lane_log.size()), 64'd8);
         check("t2_alternation", 64'(pat), 64'hAA);
      end
      drive0(5, 32'hDEADBEEF, 1'b0);
      step();
      idle_lanes();
      step();
      step();
      check("t2_done_hold", 64'(collect_done), 64'd1);
      check("t2_done_no_wr", 64'(mem_wr_en), 64'd0);

      // Six pushes while stalled: first four kept, two dropped
      mem_wr_ready = 1'b0;
      pulse_start();
      check("t3_done_cleared", 64'(collect_done), 64'd0);
      for (int i = 0; i < 6; i++) begin
         drive0(i, 32'hC0C0C000 + 32'(i), i < 4);
         step();
      end
      idle_lanes();
      step();
      check("t3_overflow", 64'(overflow_err), 64'(exp_ovf));
      mem_wr_ready = 1'b1;
      wait_drain("t3");
      repeat (4) step();

      // Full FIFO with a pop and push on the same edge
      mem_wr_ready = 1'b0;
      pulse_start();
      check("t4_overflow_cleared", 64'(overflow_err), 64'd0);
      for (int i = 0; i < 4; i++) begin
         drive0(i, 32'hD0D0D000 + 32'(i), 1'b1);
         step();
      end
      mem_wr_ready = 1'b1;
      drive0(4, 32'hD0D0D004, 1'b1);
      step();
      idle_lanes();
      check("t4_no_overflow", 64'(overflow_err), 64'd0);
      wait_drain("t4");
      repeat (3) step();
      check("t4_done_low", 64'(collect_done), 64'd0);

      // Ready toggling every cycle across an 8-word run
      mem_wr_ready = 1'b1;
      tog = 1'b1;
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         drive0(8 + i, 32'hE0000000 + 32'(i), 1'b1);
         drive1(24 + i, 32'hF0000000 + 32'(i), 1'b1);
         step();
      end
      idle_lanes();
      wait_drain("t5");
      check("t5_done_before_last", 64'(collect_done), 64'd0);
      step();
      check("t5_done", 64'(collect_done), 64'd1);
      tog = 1'b0;

      // Reset mid-run with 3 words buffered, then a fresh run
      mem_wr_ready = 1'b0;
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         drive0(12 + i, 32'h99990000 + 32'(i), 1'b0);
         step();
      end
      idle_lanes();
      reset = 1'b0;
      step();
      check("t6_rst_wr_en", 64'(mem_wr_en), 64'd0);
      check("t6_rst_wr_addr", 64'(mem_wr_addr), 64'd0);
      check("t6_rst_wr_data", 64'(mem_wr_data), 64'd0);
      check("t6_rst_done", 64'(collect_done), 64'd0);
      check("t6_rst_overflow", 64'(overflow_err), 64'd0);
      reset = 1'b1;
      mem_wr_ready = 1'b1;
      step();
      check("t6_idle_wr_en", 64'(mem_wr_en), 64'd0);
      pulse_start();
      drive0(6, 32'h12345678, 1'b1);
      step();
      drive0(7, 32'h9ABCDEF0, 1'b1);
      step();
      idle_lanes();
      wait_drain("t6");
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
